// File: rtl/cmos_cap_pkg.sv
// Shared types and widths for the OV5640 capture sequencer: FSM encoding,
// counter widths and saturating-increment helpers.
package cmos_cap_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CFG = 3'd1,
    SKIP     = 3'd2,
    WAIT_FS  = 3'd3,
    ACTIVE   = 3'd4
  } cap_state_e;

  localparam int PX_W   = 12;
  localparam int LN_W   = 11;
  localparam int FC_W   = 16;
  localparam int SK_W   = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  function automatic logic [PX_W-1:0] px_sat_inc(input logic [PX_W-1:0] v);
    return (v == {PX_W{1'b1}}) ? v : v + PX_W'(1);
  endfunction

  function automatic logic [LN_W-1:0] ln_sat_inc(input logic [LN_W-1:0] v);
    return (v == {LN_W{1'b1}}) ? v : v + LN_W'(1);
  endfunction

endpackage

// File: rtl/cmos_capture_ctrl_if.sv
// Camera parallel bus plus the frame-buffer write-FIFO port of the capture
// sequencer. master = sensor/FIFO side, slave = capture controller.
interface cmos_capture_ctrl_if;

  logic                               cmos_vsync;
  logic                               cmos_href;
  logic [cmos_cap_pkg::BYTE_W-1:0]    cmos_db;
  logic                               I_fifo_full;
  logic                               O_wr_en;
  logic [cmos_cap_pkg::WORD_W-1:0]    O_wr_data;

  modport master (
    output cmos_vsync,
    output cmos_href,
    output cmos_db,
    output I_fifo_full,
    input  O_wr_en,
    input  O_wr_data
  );

  modport slave (
    input  cmos_vsync,
    input  cmos_href,
    input  cmos_db,
    input  I_fifo_full,
    output O_wr_en,
    output O_wr_data
  );

endinterface

// File: rtl/cmos_byte_pack.sv
// Camera-bus input register, byte-phase tracking, RGB565 word assembly
// (first byte in [15:8]) and registered-href falling-edge detection.
module cmos_byte_pack
  import cmos_cap_pkg::*;
(
  input  logic              cmos_pclk,
  input  logic              I_rst_n,
  input  logic              pack_en_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [BYTE_W-1:0] db_i,
  output logic              vsync_o,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o,
  output logic              href_fall_o,
  output logic              odd_byte_o
);

  logic              vsync_q;
  logic              href_q;
  logic              href_dly_q;
  logic [BYTE_W-1:0] db_q;
  logic              phase_q;
  logic              phase_d;
  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] hi_d;

  // Pin register and pack state.
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      href_dly_q <= 1'b0;
      db_q       <= {BYTE_W{1'b0}};
      phase_q    <= 1'b0;
      hi_q       <= {BYTE_W{1'b0}};
    end else begin
      vsync_q    <= vsync_i;
      href_q     <= href_i;
      href_dly_q <= href_q;
      db_q       <= db_i;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
    end
  end

  // Phase toggles per registered byte and clears whenever href is low.
  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    if (pack_en_i && href_q) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = db_q;
      end else begin
        hi_d = hi_q;
      end
    end else begin
      phase_d = 1'b0;
    end
  end

  assign vsync_o     = vsync_q;
  assign word_vld_o  = pack_en_i & href_q & phase_q;
  assign word_o      = {hi_q, db_q};
  assign href_fall_o = href_dly_q & ~href_q;
  // Still reflects the finished line's byte parity in the href-fall cycle.
  assign odd_byte_o  = phase_q;

endmodule

// File: rtl/cmos_capture_ctrl.sv
// OV5640 capture sequencer: warm-up skip, frame alignment, FIFO write with
// drop tracking, geometry checks and ping-pong buffer select.
// Build option CAP_TEST_PATTERN_EN replaces pixel data with {line[4:0], px[10:0]}.
module cmos_capture_ctrl
  import cmos_cap_pkg::*;
#(
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int SKIP_FRAMES = 10,
  parameter bit VS_POL      = 1'b1
) (
  input  logic             cmos_pclk,
  input  logic             I_rst_n,
  input  logic             I_cfg_done,
  input  logic             I_cap_en,
  cmos_capture_ctrl_if.slave cam_if,
  output logic             O_frame_start,
  output logic             O_frame_done,
  output logic             O_frame_ok,
  output logic             O_fb_idx,
  output logic             O_overflow,
  output logic             O_geom_err,
  output logic             O_busy,
  output logic [FC_W-1:0]  O_frame_cnt
);

  localparam logic [SK_W-1:0] SKIP_LAST = (SKIP_FRAMES > 0) ? SK_W'(SKIP_FRAMES - 1) : {SK_W{1'b0}};

  logic              vsync_r_s;
  logic              word_vld_s;
  logic [WORD_W-1:0] word_s;
  logic              href_fall_s;
  logic              odd_byte_s;
  logic              vs_act_s;
  logic              fs_edge_s;
  logic              fe_edge_s;
  logic              pack_en_s;

  logic              cfg_meta_q;
  logic              cfg_sync_q;
  logic              vs_act_q;
  cap_state_e        state_q,       state_d;
  logic [SK_W-1:0]   skip_cnt_q,    skip_cnt_d;
  logic [PX_W-1:0]   px_cnt_q,      px_cnt_d;
  logic [LN_W-1:0]   line_cnt_q,    line_cnt_d;
  logic              bad_q,         bad_d;
  logic              wr_en_q,       wr_en_d;
  logic [WORD_W-1:0] wr_data_q,     wr_data_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q,  frame_done_d;
  logic              frame_ok_q,    frame_ok_d;
  logic              fb_idx_q,      fb_idx_d;
  logic              overflow_q,    overflow_d;
  logic              geom_err_q,    geom_err_d;
  logic              busy_q,        busy_d;
  logic [FC_W-1:0]   frame_cnt_q,   frame_cnt_d;

  assign pack_en_s = (state_q == ACTIVE);

  cmos_byte_pack u_pack (
    .cmos_pclk   (cmos_pclk),
    .I_rst_n     (I_rst_n),
    .pack_en_i   (pack_en_s),
    .vsync_i     (cam_if.cmos_vsync),
    .href_i      (cam_if.cmos_href),
    .db_i        (cam_if.cmos_db),
    .vsync_o     (vsync_r_s),
    .word_vld_o  (word_vld_s),
    .word_o      (word_s),
    .href_fall_o (href_fall_s),
    .odd_byte_o  (odd_byte_s)
  );

  // vs_act is high during vertical blanking regardless of sensor polarity.
  assign vs_act_s  = ~(vsync_r_s ^ VS_POL);
  assign fs_edge_s = vs_act_q & ~vs_act_s;
  assign fe_edge_s = ~vs_act_q & vs_act_s;

  // State, counters and registered outputs.
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cfg_meta_q    <= 1'b0;
      cfg_sync_q    <= 1'b0;
      vs_act_q      <= 1'b0;
      state_q       <= IDLE;
      skip_cnt_q    <= {SK_W{1'b0}};
      px_cnt_q      <= {PX_W{1'b0}};
      line_cnt_q    <= {LN_W{1'b0}};
      bad_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= {WORD_W{1'b0}};
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      fb_idx_q      <= 1'b0;
      overflow_q    <= 1'b0;
      geom_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= {FC_W{1'b0}};
    end else begin
      cfg_meta_q    <= I_cfg_done;
      cfg_sync_q    <= cfg_meta_q;
      vs_act_q      <= vs_act_s;
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      px_cnt_q      <= px_cnt_d;
      line_cnt_q    <= line_cnt_d;
      bad_q         <= bad_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      fb_idx_q      <= fb_idx_d;
      overflow_q    <= overflow_d;
      geom_err_q    <= geom_err_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Next-state, packing/drop handling, line and frame checks.
  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    px_cnt_d      = px_cnt_q;
    line_cnt_d    = line_cnt_q;
    bad_d         = bad_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    fb_idx_d      = fb_idx_q;
    overflow_d    = overflow_q;
    geom_err_d    = geom_err_q;
    frame_cnt_d   = frame_cnt_q;

    // A good frame flips the buffer the cycle after its done pulse.
    if (frame_done_q && frame_ok_q) begin
      fb_idx_d    = ~fb_idx_q;
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end else begin
      fb_idx_d    = fb_idx_q;
      frame_cnt_d = frame_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (I_cap_en) begin
          state_d    = WAIT_CFG;
          overflow_d = 1'b0;
          geom_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_CFG: begin
        skip_cnt_d = {SK_W{1'b0}};
        if (!I_cap_en) begin
          state_d = IDLE;
        end else if (cfg_sync_q) begin
          state_d = (SKIP_FRAMES == 0) ? WAIT_FS : SKIP;
        end else begin
          state_d = WAIT_CFG;
        end
      end
      SKIP: begin
        if (!I_cap_en) begin
          state_d = IDLE;
        end else if (fe_edge_s) begin
          skip_cnt_d = skip_cnt_q + SK_W'(1);
          if (skip_cnt_q == SKIP_LAST) begin
            state_d = WAIT_FS;
          end else begin
            state_d = SKIP;
          end
        end else begin
          state_d = SKIP;
        end
      end
      WAIT_FS: begin
        if (!I_cap_en) begin
          state_d = IDLE;
        end else if (fs_edge_s) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          px_cnt_d      = {PX_W{1'b0}};
          line_cnt_d    = {LN_W{1'b0}};
          bad_d         = 1'b0;
        end else begin
          state_d = WAIT_FS;
        end
      end
      ACTIVE: begin
        if (word_vld_s) begin
          px_cnt_d = px_sat_inc(px_cnt_q);
          if (cam_if.I_fifo_full) begin
            overflow_d = 1'b1;
            bad_d      = 1'b1;
          end else begin
            wr_en_d = 1'b1;
`ifdef CAP_TEST_PATTERN_EN
            wr_data_d = {line_cnt_q[4:0], px_cnt_q[10:0]};
`else
            wr_data_d = word_s;
`endif
          end
        end else begin
          wr_en_d = 1'b0;
        end
        // Line check runs before the frame check so a coincident line end counts.
        if (href_fall_s) begin
          if (odd_byte_s || (px_cnt_q != PX_W'(H_ACT))) begin
            geom_err_d = 1'b1;
            bad_d      = 1'b1;
          end else begin
            geom_err_d = geom_err_d;
          end
          line_cnt_d = ln_sat_inc(line_cnt_q);
          px_cnt_d   = {PX_W{1'b0}};
        end else begin
          line_cnt_d = line_cnt_q;
        end
        if (fe_edge_s) begin
          if (line_cnt_d != LN_W'(V_ACT)) begin
            geom_err_d = 1'b1;
            bad_d      = 1'b1;
          end else begin
            bad_d = bad_d;
          end
          frame_done_d = 1'b1;
          frame_ok_d   = ~bad_d;
          state_d      = I_cap_en ? WAIT_FS : IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = !((state_d == IDLE) || (state_d == WAIT_CFG));
  end

  assign cam_if.O_wr_en   = wr_en_q;
  assign cam_if.O_wr_data = wr_data_q;
  assign O_frame_start    = frame_start_q;
  assign O_frame_done     = frame_done_q;
  assign O_frame_ok       = frame_ok_q;
  assign O_fb_idx         = fb_idx_q;
  assign O_overflow       = overflow_q;
  assign O_geom_err       = geom_err_q;
  assign O_busy           = busy_q;
  assign O_frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Randomized frame-level bench for cmos_capture_ctrl with a frame/word
// reference model (skip counting, capture arming, geometry and drop rules).
`timescale 1ns/1ps
module tb_cmos_capture_ctrl;

  localparam int H    = 16;
  localparam int V    = 5;
  localparam int SKIP = 2;

  logic        cmos_pclk = 1'b0;
  logic        I_rst_n;
  logic        I_cfg_done;
  logic        I_cap_en;
  logic        O_frame_start;
  logic        O_frame_done;
  logic        O_frame_ok;
  logic        O_fb_idx;
  logic        O_overflow;
  logic        O_geom_err;
  logic        O_busy;
  logic [15:0] O_frame_cnt;

  cmos_capture_ctrl_if bus ();

  cmos_capture_ctrl #(
    .H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SKIP), .VS_POL(1'b1)
  ) dut (
    .cmos_pclk     (cmos_pclk),
    .I_rst_n       (I_rst_n),
    .I_cfg_done    (I_cfg_done),
    .I_cap_en      (I_cap_en),
    .cam_if        (bus),
    .O_frame_start (O_frame_start),
    .O_frame_done  (O_frame_done),
    .O_frame_ok    (O_frame_ok),
    .O_fb_idx      (O_fb_idx),
    .O_overflow    (O_overflow),
    .O_geom_err    (O_geom_err),
    .O_busy        (O_busy),
    .O_frame_cnt   (O_frame_cnt)
  );

  always #5 cmos_pclk = ~cmos_pclk;

  int cyc = 0;
  always @(posedge cmos_pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the inactive edge.
  logic [15:0] got_q[$];
  int   n_start = 0;
  int   n_done  = 0;
  logic last_ok = 1'b0;
  int   first_wr_cyc = 0;
  always @(negedge cmos_pclk) begin
    if (I_rst_n) begin
      if (bus.O_wr_en) begin
        if (got_q.size() == 0) first_wr_cyc = cyc;
        got_q.push_back(bus.O_wr_data);
      end
      if (O_frame_start) n_start++;
      if (O_frame_done) begin
        n_done++;
        last_ok = O_frame_ok;
      end
    end
  end

  // Reference model state.
  bit m_en = 0;
  int m_skip = 0;
  bit m_cur_cap = 0;
  bit m_fb = 0;
  int m_cnt = 0;
  bit m_ovf = 0;
  bit m_geom = 0;
  int exp_start = 0;
  int exp_done = 0;
  logic full_pend = 1'b0;

  task automatic model_enable();
    I_cap_en = 1'b1;
    m_en   = 1;
    m_skip = SKIP;
    m_ovf  = 0;
    m_geom = 0;
  endtask

  // One pclk: drive pins on the falling edge; FIFO-full lags one slot so it
  // lines up with the cycle in which the completed word is presented.
  task automatic tick(input logic vs, input logic hr, input logic [7:0] db, input logic nxt_full);
    @(negedge cmos_pclk);
    bus.cmos_vsync  = vs;
    bus.cmos_href   = hr;
    bus.cmos_db     = db;
    bus.I_fifo_full = full_pend;
    full_pend       = nxt_full;
  endtask

  task automatic send_frame(input int nl, input int odd_ln, input int drop_ln, input int ds,
                            input int dl, input int en_ln, input int dis_ln, input bit force_pix);
    logic [15:0] exp_q[$];
    logic [7:0]  b;
    logic [7:0]  b0;
    logic [15:0] w;
    int  nb;
    int  widx;
    int  f1f_cyc;
    bit  dropw;
    bit  fbad;
    bit  exp_ok;
    fbad    = 0;
    b0      = 8'h00;
    f1f_cyc = 0;
    exp_ok  = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    m_cur_cap = m_en && (m_skip == 0);
    if (m_cur_cap) exp_start++;
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int ln = 0; ln < nl; ln++) begin
      if (ln == en_ln) model_enable();
      if (ln == dis_ln) begin
        I_cap_en = 1'b0;
        if (!m_cur_cap) m_en = 0;
      end
      nb = (ln == odd_ln) ? 2*H - 1 : 2*H;
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        if (force_pix && ln == 0 && k == 0) b = 8'hF8;
        if (force_pix && ln == 0 && k == 1) b = 8'h1F;
        widx  = k / 2;
        dropw = (ln == drop_ln) && (k % 2 == 1) && (widx >= ds) && (widx < ds + dl);
        tick(1'b0, 1'b1, b, dropw);
        if (force_pix && ln == 0 && k == 1) f1f_cyc = cyc;
        if (k % 2 == 0) begin
          b0 = b;
        end else if (m_cur_cap) begin
          if (dropw) begin
            m_ovf = 1;
            fbad  = 1;
          end else begin
`ifdef CAP_TEST_PATTERN_EN
            w = {ln[4:0], widx[10:0]};
`else
            w = {b0, b};
`endif
            exp_q.push_back(w);
          end
        end
      end
      if (m_cur_cap && nb != 2*H) begin
        fbad   = 1;
        m_geom = 1;
      end
      repeat ($urandom_range(2, 5)) tick(1'b0, 1'b0, 8'h00, 1'b0);
    end
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    if (m_cur_cap) begin
      if (nl != V) begin
        fbad   = 1;
        m_geom = 1;
      end
      exp_done++;
      exp_ok = !fbad;
      if (!fbad) begin
        m_fb  = !m_fb;
        m_cnt = m_cnt + 1;
      end
      if (!I_cap_en) m_en = 0;
    end else if (m_en && m_skip > 0) begin
      m_skip--;
    end
    repeat (8) tick(1'b1, 1'b0, 8'h00, 1'b0);

    check_val("words", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_val($sformatf("word%0d", i), {16'h0, got_q[i]}, {16'h0, exp_q[i]});
    check_val("frame_start", n_start, exp_start);
    check_val("frame_done", n_done, exp_done);
    if (m_cur_cap) check_val("frame_ok", {31'h0, last_ok}, {31'h0, exp_ok});
    if (force_pix && m_cur_cap) begin
      check_val("wr_latency", first_wr_cyc - f1f_cyc, 2);
`ifndef CAP_TEST_PATTERN_EN
      if (got_q.size() > 0) check_val("byte_order", {16'h0, got_q[0]}, 32'h0000F81F);
`endif
    end
    check_val("fb_idx", {31'h0, O_fb_idx}, {31'h0, m_fb});
    check_val("frame_cnt", {16'h0, O_frame_cnt}, m_cnt);
    check_val("overflow", {31'h0, O_overflow}, {31'h0, m_ovf});
    check_val("geom_err", {31'h0, O_geom_err}, {31'h0, m_geom});
    check_val("busy", {31'h0, O_busy}, {31'h0, m_en});
    got_q.delete();
    m_cur_cap = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    I_rst_n         = 1'b0;
    I_cfg_done      = 1'b0;
    I_cap_en        = 1'b0;
    bus.cmos_vsync  = 1'b1;
    bus.cmos_href   = 1'b0;
    bus.cmos_db     = 8'h00;
    bus.I_fifo_full = 1'b0;
    repeat (3) @(negedge cmos_pclk);
    check_val("rst_wr_en", {31'h0, bus.O_wr_en}, 32'h0);
    check_val("rst_wr_data", {16'h0, bus.O_wr_data}, 32'h0);
    check_val("rst_flags", {25'h0, O_frame_start, O_frame_done, O_frame_ok, O_fb_idx,
                            O_overflow, O_geom_err, O_busy}, 32'h0);
    check_val("rst_frame_cnt", {16'h0, O_frame_cnt}, 32'h0);
    I_rst_n = 1'b1;
    idle(5);

    model_enable();
    idle(6);
    check_val("busy_wait_cfg", {31'h0, O_busy}, 32'h0);
    I_cfg_done = 1'b1;
    idle(6);
    check_val("busy_skip", {31'h0, O_busy}, 32'h1);

    // Two warm-up frames, then two clean captures.
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b1);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    // Backpressure: 10 word slots dropped mid-line.
    send_frame(V, -1, 2, 3, 10, -1, -1, 1'b0);
    // Odd-length line.
    send_frame(V, 1, -1, 0, 0, -1, -1, 1'b0);
    // Re-arm (clears sticky flags), skip again, then a short frame.
    I_cap_en = 1'b0;
    m_en = 0;
    idle(4);
    model_enable();
    idle(6);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    send_frame(V - 1, -1, -1, 0, 0, -1, -1, 1'b0);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    // Enable mid-frame: that frame is not captured.
    I_cap_en = 1'b0;
    m_en = 0;
    idle(4);
    send_frame(V, -1, -1, 0, 0, 2, -1, 1'b0);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    // Drop enable during a captured frame: it completes, then idles.
    send_frame(V, -1, -1, 0, 0, -1, 2, 1'b0);
    check_val("busy_after_disable", {31'h0, O_busy}, 32'h0);

    // Asynchronous reset in the middle of a captured line.
    model_enable();
    idle(6);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    send_frame(V, -1, -1, 0, 0, -1, -1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    check_val("busy_before_rst", {31'h0, O_busy}, 32'h1);
    I_rst_n = 1'b0;
    #1;
    check_val("rst_mid_wr", {15'h0, bus.O_wr_en, bus.O_wr_data}, 32'h0);
    check_val("rst_mid_flags", {25'h0, O_frame_start, O_frame_done, O_frame_ok, O_fb_idx,
                                O_overflow, O_geom_err, O_busy}, 32'h0);
    check_val("rst_mid_frame_cnt", {16'h0, O_frame_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
